// File: rtl/fpu_pkg.sv
// Shared types for the custom sign|exp|mant FPU: one-hot status codes, pipeline states, bias helper.
package fpu_pkg;

  typedef enum logic [3:0] {
    ST_EXACT     = 4'b0001,
    ST_INEXACT   = 4'b0010,
    ST_OVERFLOW  = 4'b0100,
    ST_UNDERFLOW = 4'b1000
  } fpu_status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_OPERATE,
    S_NORMALIZE,
    S_ROUND,
    S_DONE
  } fpu_state_t;

  function automatic int unsigned fpu_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
  parameter  int unsigned WIDTH = 29,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_in,
  output logic [CW-1:0]    count_c
);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    count_c = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data_in[i]) count_c = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Fixed-latency floating-point add/subtract with RNE rounding and valid/ready handshakes.
// Word layout: sign | exponent (EXP_W) | fraction (MANT_W), hidden leading 1.
module fpu_addsub_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W  = 6,
  parameter int unsigned MANT_W = 25
) (
  input  logic                    clock100KHz,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op_sub_in,
  input  logic [EXP_W+MANT_W:0]   op_A_in,
  input  logic [EXP_W+MANT_W:0]   op_B_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   data_out,
  output logic [3:0]              status_out
);

  localparam int unsigned W       = 1 + EXP_W + MANT_W;
  localparam int unsigned MW4     = MANT_W + 4;
  localparam int unsigned XW      = EXP_W + 2;
  localparam int unsigned SHW     = $clog2(MW4 + 1);
  localparam int unsigned EXP_MAX = 2 * fpu_bias(EXP_W) + 1;

  fpu_state_t             state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [W-1:0]           data_q, data_d;
  logic [3:0]             status_q, status_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic [MW4-1:0]         mx_q, mx_d, my_q, my_d;
  logic                   sx_q, sx_d, sy_q, sy_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic                   byp_q, byp_d;
  logic [W-1:0]           byp_word_q, byp_word_d;
  logic [MW4:0]           sum_q, sum_d;
  logic                   sign_q, sign_d, zero_q, zero_d;
  logic [MW4-2:0]         norm_q, norm_d;

  logic [EXP_W-1:0]       ea, eb, e_big, e_diff;
  logic [MANT_W-1:0]      fa, fb;
  logic                   a_big;
  logic [MW4-1:0]         m_big, m_sml, m_al, sh_left;
  logic [SHW-1:0]         sh, lzc_c;
  logic [2*MW4-1:0]       sh_full;
  logic                   inc, inexact;
  logic [MANT_W:0]        frac_r;
  logic signed [XW-1:0]   exp_r;

  fpu_lzc #(.WIDTH(MW4)) u_lzc (
    .data_in (sum_q[MW4-1:0]),
    .count_c (lzc_c)
  );

  // Alignment, normalisation shift and rounding datapath.
  always_comb begin
    ea      = a_q[W-2 -: EXP_W];
    eb      = b_q[W-2 -: EXP_W];
    fa      = a_q[MANT_W-1:0];
    fb      = b_q[MANT_W-1:0];
    a_big   = (ea >= eb);
    e_big   = a_big ? ea : eb;
    e_diff  = a_big ? (ea - eb) : (eb - ea);
    m_big   = {1'b1, (a_big ? fa : fb), 3'b000};
    m_sml   = {1'b1, (a_big ? fb : fa), 3'b000};
    sh      = (32'(e_diff) > MW4) ? SHW'(MW4) : SHW'(e_diff);
    sh_full = {m_sml, {MW4{1'b0}}} >> sh;
    m_al    = sh_full[2*MW4-1:MW4] | MW4'(|sh_full[MW4-1:0]);
    sh_left = sum_q[MW4-1:0] << lzc_c;
    inc     = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    inexact = |norm_q[2:0];
    frac_r  = {1'b0, norm_q[MW4-2:3]} + (MANT_W+1)'(inc);
    exp_r   = exp_q + $signed(XW'(frac_r[MANT_W]));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    status_d    = status_q;
    a_d         = a_q;
    b_d         = b_q;
    mx_d        = mx_q;
    my_d        = my_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    exp_d       = exp_q;
    byp_d       = byp_q;
    byp_word_d  = byp_word_q;
    sum_d       = sum_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    norm_d      = norm_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = op_A_in;
          b_d        = op_B_in ^ {op_sub_in, {(W-1){1'b0}}};
          in_ready_d = 1'b0;
          state_d    = S_ALIGN;
        end
      end
      S_ALIGN: begin
        mx_d       = m_big;
        my_d       = m_al;
        sx_d       = a_big ? a_q[W-1] : b_q[W-1];
        sy_d       = a_big ? b_q[W-1] : a_q[W-1];
        exp_d      = $signed(XW'(e_big));
        // A zero exponent field means exactly zero; pass the other operand through.
        byp_d      = (ea == '0) || (eb == '0);
        byp_word_d = (ea != '0) ? a_q : ((eb != '0) ? b_q : W'(0));
        state_d    = S_OPERATE;
      end
      S_OPERATE: begin
        zero_d = 1'b0;
        if (sx_q == sy_q) begin
          sum_d  = {1'b0, mx_q} + {1'b0, my_q};
          sign_d = sx_q;
        end else if (mx_q >= my_q) begin
          sum_d  = {1'b0, mx_q - my_q};
          sign_d = sx_q;
          zero_d = (mx_q == my_q);
        end else begin
          sum_d  = {1'b0, my_q - mx_q};
          sign_d = sy_q;
        end
        state_d = S_NORMALIZE;
      end
      S_NORMALIZE: begin
        if (sum_q[MW4]) begin
          norm_d = sum_q[MW4-1:1] | (MW4-1)'(sum_q[0]);
          exp_d  = exp_q + $signed(XW'(1));
        end else begin
          norm_d = sh_left[MW4-2:0];
          exp_d  = exp_q - $signed(XW'(lzc_c));
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (byp_q) begin
          data_d   = byp_word_q;
          status_d = ST_EXACT;
          if (&byp_word_q[W-2 -: EXP_W]) begin
            data_d   = W'(0);
            status_d = ST_OVERFLOW;
          end
        end else if (zero_q) begin
          data_d   = W'(0);
          status_d = ST_EXACT;
        end else if (exp_r >= $signed(XW'(EXP_MAX))) begin
          data_d   = W'(0);
          status_d = ST_OVERFLOW;
        end else if (exp_r <= $signed(XW'(0))) begin
          data_d   = W'(0);
          status_d = ST_UNDERFLOW;
        end else begin
          data_d   = {sign_q, exp_r[EXP_W-1:0], frac_r[MANT_W-1:0]};
          status_d = inexact ? ST_INEXACT : ST_EXACT;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      status_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mx_q        <= '0;
      my_q        <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      exp_q       <= '0;
      byp_q       <= 1'b0;
      byp_word_q  <= '0;
      sum_q       <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      norm_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      status_q    <= status_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      exp_q       <= exp_d;
      byp_q       <= byp_d;
      byp_word_q  <= byp_word_d;
      sum_q       <= sum_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      norm_q      <= norm_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign data_out   = data_q;
  assign status_out = status_q;

endmodule
